// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//   Integer register file of the core: 2**ADDR_W registers of DATA_W bits,
//   two combinational read ports and one synchronous write port. Register x0
//   is hardwired to zero: writes to it are dropped and reads of it return 0.
//
//   Optional feature (compile-time macro): REGFILE_BYPASS_EN
//     defined   : write-through forwarding. A read port addressing the register
//                 being written in the current cycle returns write_data before
//                 the clock edge.
//     undefined : read ports show stored register contents only.
//
// Ports
//   clk           in   1       single clock, state updates on rising edge
//   rst_n         in   1       asynchronous active-low reset, clears all regs
//   write_enable  in   1       commit write_data to write_addr on next edge
//   write_addr    in   ADDR_W  destination register index
//   write_data    in   DATA_W  data to write
//   read_addr1    in   ADDR_W  read port 1 register index
//   read_data1    out  DATA_W  contents of register read_addr1 (combinational)
//   read_addr2    in   ADDR_W  read port 2 register index
//   read_data2    out  DATA_W  contents of register read_addr2 (combinational)
// -----------------------------------------------------------------------------
module regfile #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    output logic [DATA_W-1:0] read_data1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data2
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    logic              wr_valid;

    // A write to x0 is not a write at all; this also keeps the bypass from
    // forwarding data onto a read of x0.
    assign wr_valid = write_enable && (write_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_valid) begin
            regs_d[write_addr] = write_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports. The final override forces 0 for x0 and for the whole time
    // reset is held, so a pending write (bypass build) never leaks out.
    always_comb begin
        read_data1 = regs_q[read_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (write_addr == read_addr1)) begin
            read_data1 = write_data;
        end
`endif
        if (!rst_n || (read_addr1 == '0)) begin
            read_data1 = '0;
        end
    end

    always_comb begin
        read_data2 = regs_q[read_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_valid && (write_addr == read_addr2)) begin
            read_data2 = write_data;
        end
`endif
        if (!rst_n || (read_addr2 == '0)) begin
            read_data2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic        write_enable;
    logic [5:0]  write_addr;
    logic [63:0] write_data;
    logic [5:0]  read_addr1;
    logic [63:0] read_data1;
    logic [5:0]  read_addr2;
    logic [63:0] read_data2;

    regfile #(.DATA_W(64), .ADDR_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .read_addr1   (read_addr1),
        .read_data1   (read_data1),
        .read_addr2   (read_addr2),
        .read_data2   (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        int          tag;
        logic [5:0]  a1;
        logic [5:0]  a2;
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t        exp_q[$];
    event        sample_ev;
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model: an array of register values plus the read rules.
    logic [63:0] ref_mem [64];

    function automatic logic [63:0] model_read(input logic [5:0] a);
        if (!rst_n || a == 6'd0) return 64'd0;
        if (BYPASS && write_enable && write_addr != 6'd0 && write_addr == a)
            return write_data;
        return ref_mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_mem[i] = 64'd0;
    endtask

    // One cycle: drive at edge+1, check before the next edge, then commit the
    // write into the model at the edge.
    task automatic step(input logic r, input logic we, input logic [5:0] wa,
                        input logic [63:0] wd, input logic [5:0] a1,
                        input logic [5:0] a2, input int tag);
        exp_t e;
        rst_n        = r;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr1   = a1;
        read_addr2   = a2;
        if (!r) model_clear();
        #1;
        e.tag = tag;
        e.a1  = a1;
        e.a2  = a2;
        e.e1  = model_read(a1);
        e.e2  = model_read(a2);
        exp_q.push_back(e);
        -> sample_ev;
        #2;
        @(posedge clk);
        if (rst_n && we && wa != 6'd0) ref_mem[wa] = wd;
        #1;
    endtask

    task automatic rd(input logic [5:0] a1, input logic [5:0] a2, input int tag);
        step(1'b1, 1'b0, 6'd0, 64'd0, a1, a2, tag);
    endtask

    // Monitor: pops one expectation per sample strobe and compares both ports.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: sample with no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (read_data1 !== e.e1) begin
                    n_err++;
                    $display("FAIL chk%0d port1 addr=%0d got=%h want=%h",
                             e.tag, e.a1, read_data1, e.e1);
                end
                n_cmp++;
                if (read_data2 !== e.e2) begin
                    n_err++;
                    $display("FAIL chk%0d port2 addr=%0d got=%h want=%h",
                             e.tag, e.a2, read_data2, e.e2);
                end
            end
        end
    end

    initial begin
        logic [63:0] d;
        logic [5:0]  wa, a1, a2;
        logic        we, r;

        rst_n        = 1'b0;
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        read_addr1   = '0;
        read_addr2   = '0;
        model_clear();
        @(posedge clk);
        #1;

        // Held in reset: reads are 0 and writes are ignored.
        for (int a = 1; a < 64; a += 4)
            step(1'b0, 1'b1, 6'(a), {$urandom, $urandom}, 6'(a), 6'(64 - a), 0);

        // Release and confirm nothing was written during reset.
        for (int a = 1; a < 64; a += 4) rd(6'(a), 6'(64 - a), 1);

        // Fill every register with random data and read it back.
        for (int a = 1; a < 64; a++)
            step(1'b1, 1'b1, 6'(a), {$urandom, $urandom}, 6'(a - 1), 6'($urandom), 2);

        // Mid-cycle reset pulse: the first check lands before any clock edge.
        for (int a = 1; a < 32; a++)
            step(1'b0, 1'b0, 6'd0, 64'd0, 6'(a), 6'(64 - a), 3);
        for (int a = 1; a < 64; a += 2) rd(6'(a), 6'(a + 1), 4);

        // Directed writes x1..x3 and reads.
        step(1'b1, 1'b1, 6'd1, 64'hAAAA_AAAA_AAAA_AAAA, 6'd0, 6'd0, 10);
        step(1'b1, 1'b1, 6'd2, 64'h5555_5555_5555_5555, 6'd1, 6'd0, 10);
        step(1'b1, 1'b1, 6'd3, 64'hDEAD_BEEF_CAFE_BABE, 6'd2, 6'd1, 10);
        rd(6'd1, 6'd2, 11);
        rd(6'd3, 6'd0, 11);
        rd(6'd3, 6'd3, 11);

        // Write x4 while reading it: old value (or forwarded) before the edge.
        step(1'b1, 1'b1, 6'd4, 64'h1234_5678_90AB_CDEF, 6'd1, 6'd4, 12);
        rd(6'd1, 6'd4, 13);

        // x0 write is discarded.
        step(1'b1, 1'b1, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 6'd0, 14);
        rd(6'd0, 6'd0, 15);

        // write_enable low leaves x5 untouched.
        step(1'b1, 1'b0, 6'd5, 64'h0123_4567_89AB_CDEF, 6'd5, 6'd5, 16);
        rd(6'd5, 6'd4, 17);

        // Reset after directed writes: x1..x3 read 0 immediately.
        step(1'b0, 1'b0, 6'd0, 64'd0, 6'd1, 6'd2, 18);
        step(1'b0, 1'b1, 6'd3, 64'hFFFF_0000_FFFF_0000, 6'd3, 6'd4, 18);
        rd(6'd1, 6'd2, 19);
        rd(6'd3, 6'd4, 19);

        // Randomized traffic with read/write collisions and rare resets.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            we = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            d  = {$urandom, $urandom};
            a1 = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom);
            a2 = ($urandom_range(0, 2) == 0) ? wa : 6'($urandom);
            step(r, we, wa, d, a1, a2, 100);
        end

        for (int a = 0; a < 64; a += 2) rd(6'(a), 6'(a + 1), 200);

        repeat (10) begin
            if (exp_q.size() == 0) break;
            #1;
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
